// File: rtl/led_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : led_scan_driver
// Description : Multiplexed 8-digit 7-segment scanner with double-buffered
//               frame load. Each digit slot lasts DIGIT_CYCLES clocks. The
//               first BLANK_CYCLES clocks of a slot keep all anodes off to
//               suppress ghosting. A new frame is accepted into pending
//               registers at any time. It becomes visible only at the next
//               frame wrap, so a frame is never torn mid-scan.
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous active-low reset
//               wr_en      - frame load request, qualified by wr_ready
//               wr_data    - eight hex digits, digit i = wr_data[4i+3:4i]
//               wr_mask    - digit enables, bit i lights digit i
//               dp_in      - decimal points per digit (LED_SCAN_DP_EN only)
//               wr_ready   - high when a new frame can be accepted
//               an         - active-low anode selects, registered
//               seg        - active-low {dp,g,f,e,d,c,b,a}, registered
//               frame_done - one-cycle pulse on the last cycle of a frame
// Config      : define LED_SCAN_DP_EN to build the decimal-point path.
// Revision    : 1.0 - initial release
// ============================================================================
module led_scan_driver #(
  parameter int DIGIT_CYCLES = 200_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_mask,
  input  logic [7:0]  dp_in,
  output logic        wr_ready,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] c_last_cnt  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_blank_cnt = CNT_W'(BLANK_CYCLES);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // With no blank time, slot 0 is already a drive cycle.
  localparam state_t c_rst_state = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]       idx_q, idx_d;
  state_t           state_q, state_d;

  logic [31:0] pend_data_q, act_data_q;
  logic [7:0]  pend_mask_q, act_mask_q;
  logic        pend_valid_q;

  logic [7:0] an_q, an_d;
  logic [7:0] seg_q, seg_d;

  logic       w_slot_end;
  logic       w_frame_wrap;
  logic       w_accept;
  logic [3:0] w_digit;
  logic       w_dp_n;

  assign w_slot_end   = (slot_cnt_q == c_last_cnt);
  assign w_frame_wrap = w_slot_end && (idx_q == 3'd7);
  assign w_accept     = wr_en && wr_ready;
  assign w_digit      = act_data_q[{idx_q, 2'b00} +: 4];

  // Hex to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h7F;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Slot counter and digit index
  // --------------------------------------------------------------------------
  always_comb begin
    slot_cnt_d = slot_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (w_slot_end) begin
      slot_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q <= '0;
      idx_q      <= '0;
      state_q    <= c_rst_state;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Blank/drive FSM and pin decode (decoded here, registered below)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    an_d    = 8'hFF;
    seg_d   = 8'hFF;
    // The state follows the counter value it will hold next cycle, so
    // state_q always matches slot_cnt_q.
    case (state_q)
      ST_BLANK: if (slot_cnt_d >= c_blank_cnt) state_d = ST_DRIVE;
      ST_DRIVE: if (slot_cnt_d <  c_blank_cnt) state_d = ST_BLANK;
      default:  state_d = c_rst_state;
    endcase
    if ((state_q == ST_DRIVE) && act_mask_q[idx_q]) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = {w_dp_n, hex7(w_digit)};
    end
  end

  // --------------------------------------------------------------------------
  // Frame buffers: pending is loaded by the handshake, active only at wrap
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data_q  <= '0;
      pend_mask_q  <= '0;
      pend_valid_q <= 1'b0;
      act_data_q   <= '0;
      act_mask_q   <= '0;
    end else begin
      // A pending frame means wr_ready is low, so these never collide.
      if (w_frame_wrap && pend_valid_q) begin
        act_data_q   <= pend_data_q;
        act_mask_q   <= pend_mask_q;
        pend_valid_q <= 1'b0;
      end
      if (w_accept) begin
        pend_data_q  <= wr_data;
        pend_mask_q  <= wr_mask;
        pend_valid_q <= 1'b1;
      end
    end
  end

`ifdef LED_SCAN_DP_EN
  logic [7:0] pend_dp_q, act_dp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dp_q <= '0;
      act_dp_q  <= '0;
    end else begin
      if (w_frame_wrap && pend_valid_q) act_dp_q  <= pend_dp_q;
      if (w_accept)                     pend_dp_q <= dp_in;
    end
  end

  assign w_dp_n = ~act_dp_q[idx_q];
`else
  logic w_dp_unused;
  assign w_dp_unused = ^dp_in;
  assign w_dp_n      = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 8'hFF;
      seg_q <= 8'hFF;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign wr_ready   = ~pend_valid_q;
  assign frame_done = w_frame_wrap;

endmodule
`default_nettype wire

// File: tb/tb_led_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_scan_driver
// Description : Self-checking bench for led_scan_driver. A timeline model
//               derives the expected pins from the cycle number since reset
//               release and from the times at which frames were accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_scan_driver;

  localparam int DC    = 10;
  localparam int BC    = 2;
  localparam int FRAME = 8 * DC;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        wr_en   = 1'b0;
  logic [31:0] wr_data = '0;
  logic [7:0]  wr_mask = '0;
  logic [7:0]  dp_in   = '0;
  logic        wr_ready;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  led_scan_driver #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask),
    .dp_in      (dp_in),
    .wr_ready   (wr_ready),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] seg_tab [16];

  // Model state: cycle number since release, displayed frame, pending frame
  int          t;
  logic [31:0] m_data;
  logic [7:0]  m_mask;
  logic [7:0]  m_dp;
  logic        m_have_pend;
  logic [31:0] p_data;
  logic [7:0]  p_mask;
  logic [7:0]  p_dp;
  int          p_apply;
  logic [7:0]  m_an_nx;
  logic [7:0]  m_seg_nx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t           = 0;
    m_data      = '0;
    m_mask      = '0;
    m_dp        = '0;
    m_have_pend = 1'b0;
    p_data      = '0;
    p_mask      = '0;
    p_dp        = '0;
    p_apply     = 0;
    m_an_nx     = 8'hFF;
    m_seg_nx    = 8'hFF;
  endtask

  // Pins expected one cycle after a given slot position.
  task automatic model_decode(input int slot, input int idx);
    logic [31:0] nib;
    m_an_nx  = 8'hFF;
    m_seg_nx = 8'hFF;
    if (slot >= BC && m_mask[idx]) begin
      nib      = (m_data >> (4 * idx)) & 32'hF;
      m_an_nx  = ~(8'h01 << idx);
      m_seg_nx = seg_tab[nib[3:0]];
`ifdef LED_SCAN_DP_EN
      m_seg_nx[7] = ~m_dp[idx];
`endif
    end
  endtask

  // One clock cycle: check cycle t at the falling edge, then drive inputs.
  task automatic step(input logic en, input logic [31:0] d, input logic [7:0] m,
                      input logic [7:0] dp);
    if (m_have_pend && t == p_apply) begin
      m_data      = p_data;
      m_mask      = p_mask;
      m_dp        = p_dp;
      m_have_pend = 1'b0;
    end
    chk("an", an, m_an_nx);
    chk("seg", seg, m_seg_nx);
    chk("wr_ready", wr_ready, !m_have_pend);
    chk("frame_done", frame_done, (t % FRAME) == FRAME - 1);
    model_decode(t % DC, (t / DC) % 8);
    wr_en   = en;
    wr_data = d;
    wr_mask = m;
    dp_in   = dp;
    if (en && !m_have_pend) begin
      m_have_pend = 1'b1;
      p_data      = d;
      p_mask      = m;
      p_dp        = dp;
      // Visible from the cycle after the next wrap strictly after t.
      p_apply = ((t % FRAME) == FRAME - 1) ? t + FRAME + 1 : (t / FRAME) * FRAME + FRAME;
    end
    @(posedge clk);
    @(negedge clk);
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 8'h00, 8'h00);
  endtask

  task automatic idle_until_phase(input int ph);
    for (int i = 0; i < FRAME && (t % FRAME) != ph; i++) step(1'b0, 32'h0, 8'h00, 8'h00);
  endtask

  task automatic idle_until_ready();
    for (int i = 0; i < 2 * FRAME + 2 && m_have_pend; i++) step(1'b0, 32'h0, 8'h00, 8'h00);
  endtask

  // Holds wr_en until the model accepts; ignored attempts are part of the test.
  task automatic write_when_ready(input logic [31:0] d, input logic [7:0] m, input logic [7:0] dp);
    logic was_ready;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      was_ready = !m_have_pend;
      step(1'b1, d, m, dp);
      if (was_ready) break;
    end
  endtask

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    model_reset();

    // Outputs while reset is held
    #12;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_frame_done", frame_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;

    // Idle: dark display, frame_done every frame
    idle(170);

    // Load 76543210, ignored overwrite while busy, then retry of FFFFFFFF
    idle($urandom_range(0, FRAME - 1));
    write_when_ready(32'h7654_3210, 8'hFF, 8'h00);
    step(1'b1, 32'hFFFF_FFFF, 8'hFF, 8'h01);
    idle(5);
    idle_until_ready();
    idle(FRAME);
    write_when_ready(32'hFFFF_FFFF, 8'hFF, 8'h00);
    idle(2 * FRAME);

    // Masked upper digits
    write_when_ready(32'h7654_3210, 8'h0F, 8'h00);
    idle(2 * FRAME);

    // Decimal point on digit 0 with data 0
    write_when_ready(32'h0000_0000, 8'h01, 8'h01);
    idle(2 * FRAME);

    // Handshake landing exactly on the wrap cycle
    idle_until_ready();
    idle_until_phase(FRAME - 1);
    step(1'b1, 32'h89AB_CDEF, 8'hAA, 8'h55);
    idle(3 * FRAME);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0, $urandom, 8'($urandom), 8'($urandom));
    end
    idle(FRAME);

    // Reset during digit 5 drive with a frame still pending
    write_when_ready(32'h7654_3210, 8'hFF, 8'h00);
    idle_until_ready();
    idle_until_phase(20);
    write_when_ready(32'hA5A5_A5A5, 8'hFF, 8'hFF);
    idle_until_phase(53);
    chk("pre_rst_an", an, 8'hDF);
    chk("pre_rst_seg", seg, 8'h92);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", an, 8'hFF);
    chk("async_rst_seg", seg, 8'hFF);
    chk("async_rst_wr_ready", wr_ready, 1'b1);
    chk("async_rst_frame_done", frame_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    idle(3 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_scan_driver.md
LED_SCAN_DRIVER -- requirements
Module: led_scan_driver

Interface
REQ-001 SHALL have parameter DIGIT_CYCLES, default 200_000, giving the clock cycles per digit slot, blank time included.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1_000, giving the cycles at the start of each slot with all anodes off.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  frame load request, qualified by wr_ready.
REQ-006 SHALL have port wr_data  input  32  hex digit i = wr_data[4i+3:4i], i = 0..7.
REQ-007 SHALL have port wr_mask  input  8  digit enable; bit i = 1 lights digit i.
REQ-008 SHALL have port dp_in  input  8  decimal point per digit; used only with the macro in REQ-028.
REQ-009 SHALL have port wr_ready  output  1  high when a new frame can be accepted.
REQ-010 SHALL have port an  output  8  active-low anode selects; bit i = digit i.
REQ-011 SHALL have port seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-013 SHALL run slot_cnt 0..DIGIT_CYCLES-1 and a 3-bit digit index 0..7.
- At slot_cnt = DIGIT_CYCLES-1: slot_cnt returns to 0 and the index increments.
- Index wraps 7 -> 0; that boundary is the frame wrap.
REQ-014 SHALL use two states per slot:
- BLANK: slot_cnt < BLANK_CYCLES.
- DRIVE: otherwise.
REQ-015 SHALL output an = 8'hFF and seg = 8'hFF in BLANK.
REQ-016 SHALL, in DRIVE, drive an = ~(8'h01 << idx) when active_mask[idx] = 1, else an = 8'hFF and seg = 8'hFF.
REQ-017 SHALL decode the active hex digit as follows, bit7 = 1:
- 0..7 = C0 F9 A4 B0 99 92 82 F8
- 8..F = 80 90 88 83 C6 A1 86 8E
REQ-018 SHALL register an and seg, giving 1 cycle of latency from counter state to pins.
REQ-019 SHALL capture a handshake (wr_en && wr_ready) into pending registers (data, mask, dp) and drop wr_ready the next cycle.
REQ-020 SHALL ignore wr_en while wr_ready = 0 with no side effect; the requester must hold or retry.
REQ-021 SHALL, at a frame wrap with pending valid:
- copy pending into the active registers, so the new frame starts at digit 0;
- raise wr_ready the cycle after.
REQ-022 SHALL hold a handshake that lands in the same cycle as a frame wrap in pending and apply it at the following wrap, never mid-frame.
REQ-023 SHALL assert frame_done for exactly one cycle, aligned with the cycle where idx = 7 and slot_cnt = DIGIT_CYCLES-1.
REQ-024 SHALL require BLANK_CYCLES < DIGIT_CYCLES and DIGIT_CYCLES >= 2; other values are unsupported.

Reset
REQ-025 SHALL, while rst_n = 0, immediately force:
- an = 8'hFF, seg = 8'hFF, wr_ready = 1, frame_done = 0;
- slot_cnt = 0, idx = 0;
- active and pending registers = 0, pending valid = 0.
REQ-026 SHALL apply reset asserted mid-frame immediately (asynchronous); a pending frame is discarded.
REQ-027 SHALL start the first cycle after release in BLANK of digit 0.

Configuration
REQ-028 SHALL use macro LED_SCAN_DP_EN to select the decimal-point behaviour:
- Defined: seg[7] = ~active_dp[idx] in DRIVE for enabled digits.
- Undefined: seg[7] = 1 always, dp_in is ignored and no dp registers are built.

Verification (DIGIT_CYCLES=10, BLANK_CYCLES=2)
REQ-029 SHALL cover reset/idle: rst_n = 0 then release with no write -> an = FF, seg = FF, wr_ready = 1 throughout, frame_done every 80 cycles.
REQ-030 SHALL cover load: wr_data = 32'h76543210, wr_mask = FF, one wr_en pulse ->
- wr_ready low until the next wrap, then high;
- digit 0 DRIVE an = FE seg = C0;
- digit 3 DRIVE an = F7 seg = B0;
- first 2 cycles of every slot an = FF.
REQ-031 SHALL cover masking: wr_mask = 0F -> digits 4..7 slots keep an = FF and seg = FF.
REQ-032 SHALL cover back-to-back writes: second wr_en with data 32'hFFFFFFFF while wr_ready = 0 -> ignored, display keeps 76543210; a retry after wr_ready = 1 shows 8E on all digits from the next frame.
REQ-033 SHALL cover the decimal point: dp_in = 01 with data 0:
- LED_SCAN_DP_EN defined -> digit 0 seg = 40;
- undefined -> seg = C0.
REQ-034 SHALL cover reset mid-frame: rst_n low during digit 5 DRIVE -> an = FF in the same cycle, and after release wr_ready = 1 with the display dark.
